// File: rtl/demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// demux_rr_scheduler
//   Round-robin burst scheduler in front of a 1-to-8 demultiplexer. Words from
//   a single valid/ready input stream are handed out in bursts of BURST_LEN to
//   each lane enabled in lane_mask, in ascending lane order with wrap-around.
//   Every word passes through a one-entry holding register. The register's
//   lane tag (hold_lane) steers out_valid. A word that is already held keeps
//   its destination even after sel moves on to the next lane.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          scheduler run enable (sampled in IDLE / SEARCH only)
//   lane_mask[7:0]  1 = lane may receive grants
//   in_data/valid   input word + valid
//   in_ready        combinational; depends on out_ready of the held lane
//   out_data        held word, shared by all lanes
//   out_valid[7:0]  one-hot valid for the held word's lane
//   out_ready[7:0]  per-lane backpressure
//   sel[2:0]        granted lane, drives the demux select
//   busy            FSM not in IDLE
//   burst_done      asserted in the cycle the last word of a full burst is accepted
// ---------------------------------------------------------------------------

// Per-lane slice: decodes the held word's lane tag into this lane's valid
// and reports when this lane drains the holding register.
module demux_rr_lane #(
  parameter int unsigned LANE = 0
) (
  input  logic       hold_valid,
  input  logic [2:0] hold_lane,
  input  logic       ready,
  output logic       valid,
  output logic       drain
);
  assign valid = hold_valid && (hold_lane == 3'(LANE));
  assign drain = valid && ready;
endmodule

module demux_rr_scheduler #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        lane_mask,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [2:0]        sel,
  output logic              busy,
  output logic              burst_done
);
  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, SEND} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hold_valid;
  logic [2:0]       hold_lane;
  logic [NUM_LANES-1:0] drain_vec;
  logic             drain;
  logic             accept;
  logic             last_beat;
  logic [2:0]       nxt_lane;
  logic [2:0]       idx;

  // Per-lane valid decode / drain detect
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_rr_lane #(.LANE(k)) u_lane (
      .hold_valid (hold_valid),
      .hold_lane  (hold_lane),
      .ready      (out_ready[k]),
      .valid      (out_valid[k]),
      .drain      (drain_vec[k])
    );
  end

  assign drain     = |drain_vec;
  assign busy      = (state != IDLE);
  // Register can take a new word if empty or if it empties this same cycle.
  assign in_ready  = (state == SEND) && lane_mask[sel] &&
                     (!hold_valid || out_ready[hold_lane]);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BURST_LEN - 1));
  assign burst_done = accept && last_beat;

  // Round-robin search: scan sel+8 down to sel+1 so the nearest set bit
  // after sel wins. sel+8 wraps to sel itself, so the current lane is the
  // last choice.
  always_comb begin
    nxt_lane = sel;
    idx      = sel;
    for (int i = NUM_LANES; i >= 1; i--) begin
      idx = sel + 3'(i);
      if (lane_mask[idx]) nxt_lane = idx;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (enable && (lane_mask != '0)) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (!enable || (lane_mask == '0)) begin
          state_nxt = IDLE;
        end else begin
          sel_nxt   = nxt_lane;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (last_beat) begin
            cnt_nxt   = '0;
            state_nxt = SEARCH;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (!lane_mask[sel]) begin
          // Lane withdrawn mid-burst: abandon the partial burst quietly.
          cnt_nxt   = '0;
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd7;   // first search lands on lane 0
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Holding register: load wins over drain, so a same-cycle drain+accept
  // simply reloads with hold_valid staying high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_lane  <= '0;
      out_data   <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_lane  <= sel;
      out_data   <= in_data;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
Round-robin burst scheduler for the 1-to-8 demultiplexer. It accepts one input word stream with a valid/ready handshake. It sends bursts of BURST_LEN words to each enabled output lane in turn, skipping masked lanes. Each word goes through a one-entry registered output stage. The stage's lane select drives the existing 1-to-8 demux, and the stage provides per-lane valid with per-lane backpressure.

Parameters:
DATA_W, 8, width of the data word
BURST_LEN, 4, words sent to one lane before advancing to the next (>=1)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  scheduler run enable
lane_mask  input  8  1 = lane eligible for grants
in_data  input  DATA_W  input word
in_valid  input  1  in_data valid
in_ready  output  1  scheduler accepts in_data this cycle
out_data  output  DATA_W  registered word, shared by all lanes
out_valid  output  8  one-hot; bit k = out_data valid for lane k
out_ready  input  8  lane k can take a word
sel  output  3  currently granted lane (feeds the demux select)
busy  output  1  FSM not in IDLE
burst_done  output  1  one-cycle pulse when the last word of a burst is accepted

Behaviour:
- Reset values (asynchronous, while rst_n=0): state IDLE, sel=3'd7, beat count 0, hold_valid 0, hold_lane 0, out_data 0, out_valid 0, in_ready 0, busy 0, burst_done 0.
- Holding register:
  - Stores hold_valid, hold_lane and out_data.
  - out_valid[k] = hold_valid && hold_lane==k.
  - Word leaves when out_ready[hold_lane]=1 while hold_valid=1.
- in_ready = (state==SEND) && lane_mask[sel] && (!hold_valid || out_ready[hold_lane]). It is combinational from out_ready.
- Accept = in_valid && in_ready. On accept:
  - out_data <= in_data, hold_lane <= sel, hold_valid <= 1.
  - Latency is 1 cycle: a word accepted in cycle N is visible in cycle N+1.
  - Full throughput is one word per cycle when out_ready is held high.
- Drain without accept: hold_valid <= 0. Drain and accept in the same cycle: register reloads and hold_valid stays 1.
- out_data and hold_lane stay stable while hold_valid=1 and the lane is not ready. hold_lane, not sel, steers out_valid, so a word in the register is never re-routed when sel advances.
- FSM states:
  - IDLE: busy=0. Go to SEARCH when enable=1 and lane_mask!=0.
  - SEARCH: lasts exactly one cycle.
    - Next lane = first set bit of lane_mask in the order sel+1, sel+2, …, sel+8 (mod 8). The current lane is checked last.
    - Load sel with that lane, clear the count and go to SEND.
    - If lane_mask==0 or enable==0, go to IDLE and leave sel unchanged.
  - SEND:
    - Each accept increments count.
    - The accept with count==BURST_LEN-1 pulses burst_done, clears count and goes to SEARCH.
    - If lane_mask[sel] drops mid-burst, there are no further accepts; go to SEARCH next cycle. The partial burst ends without a burst_done pulse.
    - enable=0 mid-burst is ignored until the burst ends; SEARCH then goes to IDLE.
- First grant after reset is lane 0 if unmasked (sel resets to 7).
- A single enabled lane is re-granted every burst, with one SEARCH bubble cycle between bursts.
- in_valid low mid-burst: the FSM waits in SEND indefinitely; count is held.
- A held word still drains in IDLE and SEARCH; the FSM does not wait for the drain.
- Reset mid-operation discards the held word and any partial burst.

Test Plan:
1. Reset, then enable=1, mask=8'hFF, BURST_LEN=4, in_valid=1, all out_ready=1, in_data 0,1,2,… ->
   - words 0–3 appear on lane 0, 4–7 on lane 1, …, 28–31 on lane 7, 32 on lane 0;
   - one in_ready=0 bubble per burst (the SEARCH cycle);
   - burst_done pulses on words 3, 7, 11, …
2. mask=8'b1010_0100 ->
   - grant order is lanes 2, 5, 7, 2;
   - out_valid never asserts on a masked lane.
3. Lane 0 busy: out_ready[0]=0 for 5 cycles after the first word is accepted ->
   - out_valid=8'h01 and out_data are held constant;
   - in_ready=0;
   - the next word is accepted in the same cycle out_ready[0] rises.
4. lane_mask[1] cleared after 2 of 4 words to lane 1 ->
   - no further accepts for lane 1;
   - no burst_done pulse;
   - both words still deliver on lane 1;
   - next grant is lane 2.
5. enable=0 in the middle of the lane-3 burst ->
   - the burst completes (4 words);
   - after SEARCH the FSM goes to IDLE (busy=0, in_ready=0);
   - re-enable -> next grant is lane 4.
6. rst_n pulsed low for 1 cycle with hold_valid=1 mid-burst ->
   - out_valid=0, sel=7 and in_ready=0 immediately;
   - after release, the first grant is lane 0.
